// File: rtl/adc_frontend_if.sv
// Conditioned sample stream from adc_frontend into pdh_core.
// The driver owns both samples and the shared valid strobe.
interface adc_frontend_if #(
    parameter int ADC_DATA_WIDTH = 16
);
    logic signed [ADC_DATA_WIDTH-1:0] adc_a_o;
    logic signed [ADC_DATA_WIDTH-1:0] adc_b_o;
    logic                             valid_o;

    modport master (output adc_a_o, adc_b_o, valid_o);
    modport slave  (input  adc_a_o, adc_b_o, valid_o);
endinterface

// File: rtl/adc_frontend.sv
// ADC input conditioning: capture, inverted-code decode, saturating DC offset
// removal, and a shared-window boxcar average/decimate by 2^k.
module adc_frontend #(
    parameter int ADC_IN_WIDTH   = 14,
    parameter int ADC_DATA_WIDTH = 16,
    parameter int AVG_LOG2_MAX   = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADC_IN_WIDTH-1:0]          adc_dat_a_i,
    input  logic [ADC_IN_WIDTH-1:0]          adc_dat_b_i,
    input  logic signed [ADC_DATA_WIDTH-1:0] dc_offset_a_i,
    input  logic signed [ADC_DATA_WIDTH-1:0] dc_offset_b_i,
    input  logic [2:0]                       avg_log2_i,
    input  logic                             clr_sat_i,
    adc_frontend_if.master                   core_if,
    output logic                             sat_a_o,
    output logic                             sat_b_o,
    output logic                             adc_csn_o
);
    localparam int DW = ADC_DATA_WIDTH;
    localparam int IW = ADC_IN_WIDTH;
    localparam int AW = ADC_DATA_WIDTH + AVG_LOG2_MAX;
    localparam int KW = $clog2(AVG_LOG2_MAX + 1);
    localparam int CW = AVG_LOG2_MAX + 1;

    // Returns {clamp_event, y}: y = decode(raw) - off, clamped to the DW-bit range.
    function automatic logic [DW:0] f_cond(input logic [IW-1:0] raw,
                                           input logic [DW-1:0] off);
        logic [IW-1:0] x;
        logic [DW:0]   d;
        x = {raw[IW-1], ~raw[IW-2:0]};
        d = {{(DW+1-IW){x[IW-1]}}, x} - {off[DW-1], off};
        if (d[DW] != d[DW-1])
            return {1'b1, d[DW], {(DW-1){~d[DW]}}};
        return {1'b0, d[DW-1:0]};
    endfunction

    logic [IW-1:0]        r_raw_a, r_raw_b;
    logic signed [DW-1:0] r_y_a, r_y_b;
    logic                 r_clp_a, r_clp_b;
    logic signed [AW-1:0] r_acc_a, r_acc_b;
    logic [CW-1:0]        r_cnt;
    logic [KW-1:0]        r_kact;
    logic signed [DW-1:0] r_out_a, r_out_b;
    logic                 r_valid;
    logic                 r_sat_a, r_sat_b;

    logic [KW-1:0]        w_kreq, w_k;
    logic                 w_first, w_last;
    logic signed [AW-1:0] w_sum_a, w_sum_b;

    always_comb begin
        w_kreq  = (int'(avg_log2_i) > AVG_LOG2_MAX) ? KW'(AVG_LOG2_MAX) : KW'(avg_log2_i);
        w_first = (r_cnt == '0);
        w_k     = w_first ? w_kreq : r_kact;
        w_last  = (r_cnt == CW'((1 << w_k) - 1));
        // First sample of a window starts from zero so k=0 never sees a stale sum
        w_sum_a = (w_first ? AW'(0) : r_acc_a) + {{(AW-DW){r_y_a[DW-1]}}, r_y_a};
        w_sum_b = (w_first ? AW'(0) : r_acc_b) + {{(AW-DW){r_y_b[DW-1]}}, r_y_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw_a <= '0;
            r_raw_b <= '0;
            r_y_a   <= '0;
            r_y_b   <= '0;
            r_clp_a <= 1'b0;
            r_clp_b <= 1'b0;
            r_acc_a <= '0;
            r_acc_b <= '0;
            r_cnt   <= '0;
            r_kact  <= '0;
            r_out_a <= '0;
            r_out_b <= '0;
            r_valid <= 1'b0;
            r_sat_a <= 1'b0;
            r_sat_b <= 1'b0;
        end else begin
            r_raw_a            <= adc_dat_a_i;
            r_raw_b            <= adc_dat_b_i;
            {r_clp_a, r_y_a}   <= f_cond(r_raw_a, dc_offset_a_i);
            {r_clp_b, r_y_b}   <= f_cond(r_raw_b, dc_offset_b_i);
            // Flags move with the clamped sample into the averager; set beats clear
            r_sat_a <= r_clp_a | (r_sat_a & ~clr_sat_i);
            r_sat_b <= r_clp_b | (r_sat_b & ~clr_sat_i);
            if (w_first)
                r_kact <= w_kreq;
            if (w_last) begin
                r_out_a <= DW'(w_sum_a >>> w_k);
                r_out_b <= DW'(w_sum_b >>> w_k);
                r_valid <= 1'b1;
                r_cnt   <= '0;
            end else begin
                r_acc_a <= w_sum_a;
                r_acc_b <= w_sum_b;
                r_valid <= 1'b0;
                r_cnt   <= r_cnt + CW'(1);
            end
        end
    end

    assign core_if.adc_a_o = r_out_a;
    assign core_if.adc_b_o = r_out_b;
    assign core_if.valid_o = r_valid;
    assign sat_a_o         = r_sat_a;
    assign sat_b_o         = r_sat_b;
    assign adc_csn_o       = 1'b1;
endmodule
